// File: rtl/uart_tx_sched.sv
// Round-robin merge of two byte producers into a FIFO that feeds a single
// async_transmitter, one start/busy/done handshake per byte.
module uart_tx_sched #(
   parameter int unsigned DEPTH_LOG2   = 4,
   parameter int unsigned BUSY_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [7:0]            req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [7:0]            req1_data,
   output logic                  req1_ready,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   input  logic                  tx_busy,
   output logic                  byte_sent,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  fifo_full,
   output logic                  fifo_empty
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned TW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [TW-1:0] WAIT_LAST = TW'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  last_grant;
   logic [TW-1:0]         wait_cnt;
   logic [TW-1:0]         wait_cnt_next;
   logic                  grant0;
   logic                  grant1;
   logic                  push;
   logic                  pop;
   logic                  sent_next;
   logic [7:0]            push_data;

   assign fifo_count = count;
   assign fifo_full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
   assign fifo_empty = (count == '0);

   // Idle or contended cycles both offer the slot to whoever did not win last.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!fifo_full) begin
         if (req0_valid != req1_valid) begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
         end else begin
            req0_ready = last_grant;
            req1_ready = !last_grant;
         end
      end
   end

   assign grant0    = req0_valid && req0_ready;
   assign grant1    = req1_valid && req1_ready;
   assign push      = grant0 || grant1;
   assign push_data = grant0 ? req0_data : req1_data;

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      pop           = 1'b0;
      sent_next     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && !tx_busy) begin
               pop           = 1'b1;
               wait_cnt_next = '0;
               state_next    = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_next = WAIT_DONE;
            end else if (wait_cnt == WAIT_LAST) begin
               state_next = IDLE;
            end else begin
               wait_cnt_next = wait_cnt + TW'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               sent_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         last_grant <= 1'b1;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         byte_sent  <= 1'b0;
      end else begin
         state     <= state_next;
         wait_cnt  <= wait_cnt_next;
         tx_start  <= pop;
         byte_sent <= sent_next;
         if (pop) begin
            tx_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
         end
         if (push) begin
            wr_ptr     <= wr_ptr + DEPTH_LOG2'(1);
            last_grant <= !grant0;
         end
         if (push && !pop) begin
            count <= count + (DEPTH_LOG2 + 1)'(1);
         end else if (pop && !push) begin
            count <= count - (DEPTH_LOG2 + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares the single UART transmitter (async_transmitter: TxD_start / TxD_data / TxD_busy) between two byte producers.
  - Requester 0: CPU path from the config-register UART write.
  - Requester 1: debug / boot message source.
- Merges the producers round-robin into one DEPTH-entry byte FIFO, then sequences the transmitter one byte at a time.
- Sits between the config-register block and the transmitter instance, replacing the direct start/data drive.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 bytes).
- BUSY_TIMEOUT, 4, max cycles to wait for tx_busy to rise after tx_start before abandoning the handshake.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  requester 0 byte accepted this cycle if valid
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  8  requester 1 byte
- req1_ready  out  1  requester 1 byte accepted this cycle if valid
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_data  out  8  byte to transmitter; held stable between starts
- tx_busy  in  1  transmitter busy
- byte_sent  out  1  one-cycle pulse when a byte's transmission completes
- fifo_count  out  DEPTH_LOG2+1  bytes currently queued
- fifo_full  out  1  fifo_count == DEPTH
- fifo_empty  out  1  fifo_count == 0

Behaviour:
- Reset (async, active-high):
  - FSM = IDLE; FIFO pointers and count = 0.
  - tx_start = 0, tx_data = 0, byte_sent = 0; fifo_empty = 1, fifo_full = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- Reset mid-transmission drops all queued bytes. The transmitter finishes its current byte on its own.
- Enqueue arbitration (combinational ready):
  - Both ready outputs are 0 when fifo_full (registered) is 1.
  - Otherwise, with only one valid asserted, that requester's ready = 1.
  - With both valid, ready goes to the requester that is not last_grant.
  - With neither valid, req0_ready = 1 if it is not last_grant, else req1_ready = 1.
  - Transfer occurs when valid && ready. The byte is written at the write pointer, which then increments modulo DEPTH.
  - last_grant updates only on a transfer.
  - At most one push per cycle.
  - No push while full, even if a pop occurs in the same cycle.
- Count: push only → +1; pop only → −1; push and pop in the same cycle → unchanged.
- Pointers: DEPTH_LOG2 bits each, wrapping from DEPTH−1 to 0.
- TX FSM:
  - IDLE:
    - Stay while fifo_empty or tx_busy.
    - Otherwise pop the head; next cycle tx_data = head byte and tx_start = 1. Go to WAIT_BUSY and clear the timeout counter.
    - Latency: a byte pushed into an empty FIFO with the transmitter idle has tx_start high 2 cycles after the push cycle.
  - WAIT_BUSY:
    - tx_start = 0.
    - If tx_busy = 1, go to WAIT_DONE.
    - Else increment the counter. When it reaches BUSY_TIMEOUT, go to IDLE with no byte_sent; the byte is considered lost.
  - WAIT_DONE:
    - Stay while tx_busy = 1.
    - On tx_busy = 0, pulse byte_sent for 1 cycle and go to IDLE.
    - The next start can issue at the earliest 1 cycle after byte_sent.
- tx_start is registered and never high for 2 consecutive cycles.
- tx_data changes only in the cycle tx_start rises.
- Requesters may drop valid without a transfer; there is no data-stability requirement on them.

Test Plan:
- Reset, then push 0x41 on req0 only, with tx_busy driven by a model that goes high the cycle after start for 10 cycles → tx_start at push+2 with tx_data = 0x41; byte_sent 1 cycle after tx_busy falls; fifo_count returns to 0.
- Both requesters hold valid with bytes 0x10.. and 0x20.. while tx_busy is held high → accepted order 0x10, 0x20, 0x11, 0x21, …; ready drops when fifo_count = 16; on release, transmit order matches accept order.
- FIFO full while a pop occurs and both requesters are valid → no push that cycle; fifo_count goes 16 → 15; the push succeeds next cycle (count back to 16).
- tx_busy tied low after start → FSM returns to IDLE after 4 WAIT_BUSY cycles; byte_sent never pulses; next byte starts on the following IDLE cycle.
- Assert reset during WAIT_DONE with 5 bytes queued → outputs immediately at reset values; fifo_empty = 1; after release, no tx_start until a new push.
- Write pointer wrap: 40 bytes streamed through with a varying tx_busy model → all 40 bytes appear on tx_data in order, no duplicates or drops.
